// File: rtl/booth_mul_seq_if.sv
// booth_mul_seq_if: request/result bundle between the ALU issue logic and the Booth multiplier
//   master (issue side): drives start, abort, multiplicand, multiplier; observes busy, done, product
//   slave  (multiplier): observes the request signals; drives busy, done, product
interface booth_mul_seq_if #(
    parameter int WIDTH = 32
);
    logic                 start;
    logic                 abort;
    logic [WIDTH-1:0]     multiplicand;
    logic [WIDTH-1:0]     multiplier;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;

    modport master (
        output start, abort, multiplicand, multiplier,
        input  busy, done, product
    );

    modport slave (
        input  start, abort, multiplicand, multiplier,
        output busy, done, product
    );
endinterface

// File: rtl/booth_mul_seq.sv
// booth_mul_seq: multi-cycle signed WIDTH x WIDTH -> 2*WIDTH radix-2 Booth multiplier
//   clk    rising-edge clock
//   clr_n  asynchronous active-low reset
//   bus    slave side of booth_mul_seq_if
//          start/multiplicand/multiplier: request, sampled in IDLE only
//          abort: cancels a multiply while in RUN
//          busy: high in RUN; done: one-cycle pulse in DONE; product: last completed result
module booth_mul_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic              clk,
    input  logic              clr_n,
    booth_mul_seq_if.slave    bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WIDTH:0]       a_q, a_d;
    logic [WIDTH:0]       q_q, q_d;
    logic [WIDTH-1:0]     m_q, m_d;
    logic [2*WIDTH-1:0]   product_q, product_d;
    logic [WIDTH:0]       m_ext, addend, sum, step_a, step_q;
    logic                 last_step;

    // One Booth step: A is WIDTH+1 bits so that negating M = most-negative value cannot overflow.
    always_comb begin
        m_ext     = {m_q[WIDTH-1], m_q};
        addend    = (q_q[1:0] == 2'b01) ? m_ext :
                    (q_q[1:0] == 2'b10) ? (~m_ext) + ONE : '0;
        sum       = a_q + addend;
        // Arithmetic right shift of {A, Q}: sign of A replicated, A[0] enters Q's MSB.
        step_a    = {sum[WIDTH], sum[WIDTH:1]};
        step_q    = {sum[0], q_q[WIDTH:1]};
        last_step = (cnt_q == CNT_W'(WIDTH - 1));
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        q_d       = q_q;
        m_d       = m_q;
        product_d = product_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    m_d     = bus.multiplicand;
                    a_d     = '0;
                    q_d     = {bus.multiplier, 1'b0};
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (bus.abort) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    a_d   = step_a;
                    q_d   = step_q;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (last_step) begin
                        // Q[0] is the Booth guard bit, so the low half sits in Q[WIDTH:1].
                        product_d = {step_a[WIDTH-1:0], step_q[WIDTH:1]};
                        state_d   = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            a_q       <= '0;
            q_q       <= '0;
            m_q       <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            a_q       <= a_d;
            q_q       <= q_d;
            m_q       <= m_d;
            product_q <= product_d;
        end
    end

    assign bus.busy    = (state_q == RUN);
    assign bus.done    = (state_q == DONE);
    assign bus.product = product_q;
endmodule

// File: tb/tb_booth_mul_seq.sv
// tb_booth_mul_seq: directed self-checking bench for booth_mul_seq
module tb_booth_mul_seq;
    logic clk = 1'b0;
    logic clr_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    booth_mul_seq_if #(.WIDTH(32)) bus ();

    booth_mul_seq #(.WIDTH(32), .CNT_W(6)) dut (
        .clk   (clk),
        .clr_n (clr_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic do_mul(input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp, input string name);
        logic [63:0] prev;
        int nb, lat;
        bit seen, stable;
        @(negedge clk);
        bus.multiplicand = a;
        bus.multiplier   = b;
        bus.start        = 1'b1;
        prev   = bus.product;
        seen   = 1'b0;
        stable = 1'b1;
        nb     = 0;
        lat    = 0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            bus.start        = 1'b0;
            bus.multiplicand = $urandom;
            bus.multiplier   = $urandom;
            if (bus.busy) nb++;
            if (bus.done) begin
                seen = 1'b1;
                lat  = i;
                break;
            end
            if (bus.product !== prev) stable = 1'b0;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s timeout: done=0 after 100 cycles, required done pulse", name);
        end else begin
            checks += 4;
            if (bus.product !== exp) begin
                errors++;
                $display("FAIL %s product: got %h, expected %h", name, bus.product, exp);
            end
            if (lat != 33) begin
                errors++;
                $display("FAIL %s latency: got %0d, expected 33", name, lat);
            end
            if (nb != 32) begin
                errors++;
                $display("FAIL %s busy cycles: got %0d, expected 32", name, nb);
            end
            if (!stable) begin
                errors++;
                $display("FAIL %s product stable during RUN: got changed, expected %h held", name, prev);
            end
        end
    endtask

    task automatic test_reset();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.multiplicand = '0;
        bus.multiplier = '0;
        clr_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.busy, bus.done, bus.product} !== 66'd0) begin
            errors++;
            $display("FAIL reset outputs: got busy=%b done=%b product=%h, expected 0 0 0", bus.busy, bus.done, bus.product);
        end
        clr_n = 1'b1;
    endtask

    task automatic test_basic();
        do_mul(32'd3, 32'hFFFFFFFB, 64'hFFFFFFFFFFFFFFF1, "3x-5");
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL done one-cycle: got done=%b busy=%b, expected 0 0", bus.done, bus.busy);
        end
    endtask

    task automatic test_corners();
        do_mul(32'h80000000, 32'h80000000, 64'h4000000000000000, "min x min");
        do_mul(32'h80000000, 32'd1, 64'hFFFFFFFF80000000, "min x 1");
    endtask

    task automatic test_back_to_back();
        do_mul(32'h12345678, 32'd0, 64'd0, "x0");
        do_mul(32'h7FFFFFFF, 32'h7FFFFFFF, 64'h3FFFFFFF00000001, "max x max");
        do_mul(32'hFFFFFFFF, 32'hFFFFFFFF, 64'd1, "-1 x -1");
    endtask

    task automatic test_ignored_start();
        int nb, nd;
        @(negedge clk);
        bus.multiplicand = 32'd6;
        bus.multiplier   = 32'd7;
        bus.start        = 1'b1;
        nb = 0;
        nd = 0;
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            if (bus.busy) nb++;
            if (bus.done) nd++;
            bus.start = (nb == 10) && bus.busy;
            bus.multiplicand = 32'd9;
            bus.multiplier   = 32'd9;
        end
        bus.start = 1'b0;
        checks += 2;
        if (nd != 1) begin
            errors++;
            $display("FAIL ignored start done count: got %0d, expected 1", nd);
        end
        if (bus.product !== 64'd42) begin
            errors++;
            $display("FAIL ignored start product: got %h, expected %h", bus.product, 64'd42);
        end
    endtask

    task automatic test_abort();
        int nb, nd;
        bit hit;
        do_mul(32'd6, 32'd7, 64'd42, "6x7");
        @(negedge clk);
        bus.multiplicand = 32'd100;
        bus.multiplier   = 32'd100;
        bus.start        = 1'b1;
        nb  = 0;
        hit = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.busy) nb++;
            if (nb == 15) begin
                bus.abort = 1'b1;
                hit = 1'b1;
                break;
            end
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL abort setup: got %0d busy cycles, expected 15", nb);
        end
        @(negedge clk);
        bus.abort = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.product !== 64'd42) begin
            errors++;
            $display("FAIL abort state: got busy=%b done=%b product=%h, expected 0 0 %h", bus.busy, bus.done, bus.product, 64'd42);
        end
        nd = 0;
        nb = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done) nd++;
            if (bus.busy) nb++;
        end
        checks++;
        if (nd != 0 || nb != 0) begin
            errors++;
            $display("FAIL abort quiet: got done=%0d busy=%0d cycles, expected 0 0", nd, nb);
        end
        do_mul(32'd2, 32'd3, 64'd6, "2x3 after abort");
    endtask

    task automatic test_reset_mid();
        int nb, nd;
        bit hit;
        @(negedge clk);
        bus.multiplicand = 32'd5;
        bus.multiplier   = 32'd5;
        bus.start        = 1'b1;
        nb  = 0;
        hit = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.busy) nb++;
            if (nb == 20) begin
                hit = 1'b1;
                break;
            end
        end
        #2 clr_n = 1'b0;
        #1;
        checks++;
        if (!hit || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.product !== 64'd0) begin
            errors++;
            $display("FAIL mid reset: got reached=%b busy=%b done=%b product=%h, expected 1 0 0 0", hit, bus.busy, bus.done, bus.product);
        end
        @(negedge clk);
        clr_n = 1'b1;
        nd = 0;
        nb = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done) nd++;
            if (bus.busy) nb++;
        end
        checks++;
        if (nd != 0 || nb != 0 || bus.product !== 64'd0) begin
            errors++;
            $display("FAIL post reset quiet: got done=%0d busy=%0d product=%h, expected 0 0 0", nd, nb, bus.product);
        end
        do_mul(32'd5, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFB, "5x-1 after reset");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_corners();
        test_back_to_back();
        test_ignored_start();
        test_abort();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/booth_mul_seq.md
Name: booth_mul_seq

Overview:
- Multi-cycle signed 32x32 -> 64 radix-2 Booth multiplier controller for the CPU's MUL path (HI/LO result).
- Holds the A/Q/M registers and a 33-bit Booth iteration datapath, and performs one Booth step per clock for 32 steps.
- Sits between the ALU issue logic (start/operands) and the HI/LO register write-back (product/done).

Parameters:
- WIDTH, 32, operand width. The product is 2*WIDTH. The iteration count equals WIDTH.
- CNT_W, 6, iteration counter width. Must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  rising-edge clock.
- clr_n  in  1  asynchronous active-low reset.
- start  in  1  request a multiply. Sampled only in IDLE.
- abort  in  1  cancel an in-flight multiply. Effective in RUN only.
- multiplicand  in  WIDTH  M operand, signed, captured on start.
- multiplier  in  WIDTH  Q operand, signed, captured on start.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse when product becomes valid.
- product  out  2*WIDTH  last completed signed product, registered.

Behaviour:
- Reset (clr_n=0, async):
  - state=IDLE, counter=0, A/Q/M=0.
  - busy=0, done=0, product=0.
- States: IDLE, RUN, DONE.
  - IDLE, start=1 at edge E0:
    - Load M <- multiplicand, A <- 0 (WIDTH+1 bits), Q <- {multiplier, 1'b0} (WIDTH+1 bits), counter <- 0.
    - Go to RUN.
  - RUN, each edge E1..E32 performs one Booth step on (A, Q), then increments counter:
    - Q[1:0]=00/11: no add.
    - Q[1:0]=01: A+M.
    - Q[1:0]=10: A-M, done as A + ~M + 1 at WIDTH+1 bits.
    - Then arithmetic right shift of the concatenation {A, Q}. A's MSB is replicated; A[0] shifts into Q[WIDTH].
  - Accumulator width:
    - A is WIDTH+1 bits; M is sign-extended to WIDTH+1 for the add/subtract.
    - This is mandatory so that M = 0x80000000 does not overflow.
  - End of RUN:
    - On the edge where counter reaches WIDTH (E32), product <- {A[WIDTH-1:0], Q[WIDTH:1]} from the post-step values.
    - Same edge: state -> DONE.
  - DONE: done=1 for exactly one cycle. The next edge returns to IDLE.
- Latency:
  - start sampled at E0; done high in the cycle after E32, i.e. 33 cycles after the start edge.
  - Throughput is one multiply per 34 cycles (E0 load, E1..E32 steps, DONE cycle).
- busy:
  - High in the cycles following E0 through E32.
  - Low in IDLE and DONE.
- start handling:
  - start while in RUN or DONE is ignored: no queuing, operands are not re-captured.
  - Operand inputs are don't-care except at E0.
- abort handling:
  - abort=1 at any RUN edge returns to IDLE on that edge: no step is applied, counter=0.
  - done is not pulsed; product keeps its previous value.
  - abort in IDLE/DONE has no effect.
  - abort and start together in IDLE: start wins, because abort applies in RUN only.
- product changes only on the final-step edge or on reset. It holds stable otherwise, including during RUN.
- Reset asserted mid-RUN: immediate return to reset values, and no done pulse after release.
- Counter saturates by design: it never exceeds WIDTH because RUN exits at WIDTH.

Test Plan:
1. Reset then start with multiplicand=3, multiplier=-5 (0xFFFFFFFB) -> busy high for 32 cycles; done pulse 33 cycles after start; product=0xFFFFFFFFFFFFFFF1.
2. multiplicand=0x80000000, multiplier=0x80000000 -> product=0x4000000000000000. Also multiplicand=0x80000000, multiplier=1 -> product=0xFFFFFFFF80000000.
3. multiplicand=0x12345678, multiplier=0 -> product=0. Then 0x7FFFFFFF x 0x7FFFFFFF -> product=0x3FFFFFFF00000001. Back-to-back starts, second start issued the cycle after done.
4. Start 6x7, pulse start again with 9x9 at cycle 10 of RUN -> ignored; product=42 (0x2A); exactly one done pulse.
5. Complete 6x7 (product=42). Start 100x100, assert abort at cycle 15 -> IDLE next cycle, no done, product stays 42. A fresh start 2x3 then yields 6.
6. Start 5x5, drop clr_n asynchronously mid-cycle at step 20 -> busy/done/product immediately 0. After release, no done pulse until a new start.
